encoder_16x4_seq: RTL
=====================

Name: encoder_16x4_seq

Overview:
- Sequential 16-to-4 priority encoder; the inverse of the team's 4x16 decoder.
- Captures a 16-bit request word, then emits the 4-bit index of each set bit, one per handshake, highest index first.
- Raises a one-cycle done pulse when the word is exhausted.
- Sits downstream of request sources; its code output can drive a 4x16 decoder to re-expand one-hot selects.

Parameters:
- N, 16, number of request lines (fixed at 16 for this revision).
- W, 4, code width, log2(N).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  capture D when idle
- D  input  16  request lines; D[15] has highest priority
- ready  input  1  consumer accepts current code
- code  output  4  index of highest set pending bit
- valid  output  1  code is meaningful
- busy  output  1  pending word non-empty
- count  output  5  number of pending bits, 0..16
- done  output  1  one-cycle pulse at end of word

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at a clk edge):
  - pending=0, state=IDLE.
  - code=4'b0000, valid=0, busy=0, count=0, done=0.
  - Applies mid-operation; any word in progress is discarded with no done pulse.
- State register: pending[15:0].
- FSM states: IDLE, SCAN.
- IDLE:
  - valid=0, busy=0, code=0.
  - On an edge with load=1 and D!=0: pending<=D, count<=popcount(D), go to SCAN.
  - On an edge with load=1 and D==0: pending stays 0; done=1 for the following cycle; stay in IDLE.
  - Latency: load sampled at edge k gives valid=1 in the cycle after edge k.
- SCAN:
  - valid=1, busy=1.
  - code = index of highest set bit of pending (registered-state derived, no dependence on D).
  - An edge with valid&&ready clears pending[code] and decrements count.
  - If the cleared bit was the last one: go to IDLE; done=1 for exactly the next cycle; valid=0 in that cycle.
  - ready=0: hold code, count and pending unchanged indefinitely.
  - load is ignored while in SCAN, including when load coincides with the final handshake. A new word is accepted only on an edge in IDLE.
- done: single-cycle pulse, registered, never asserted together with valid.
- count: always equals popcount(pending).
- Width rules: code is 4 bits with no wrap needed; count is 5 bits to hold 16.
- D=16'hFFFF: emits 15,14,...,0 over 16 handshakes.
- X/Z on D while idle with load=0 has no effect.

Decomposition:
- Shared package/header (enc_pkg): constants N=16, W=4, CW=5; state encodings IDLE=1'b0, SCAN=1'b1.
- One natural sub-module: priority_encoder_16x4 (combinational; 16-bit in, 4-bit index plus any-set flag; highest index wins). Instantiated on pending.
- Popcount is computed once at load in the top level.

Test Plan:
- Reset mid-scan: load D=16'h00F0, take 2 handshakes, assert reset -> next cycle valid=0, busy=0, count=0, code=0; no done pulse.
- Single bit: load D=16'h0001, ready=1 -> one cycle later valid=1, code=0, count=1. The next edge clears it; done=1 for one cycle, then idle.
- Priority order: load D=16'h8421, ready=1 -> codes 15,11,6... corrected: codes 15,10,5,0 on consecutive cycles; count 4,3,2,1; then done pulse.
- Backpressure: load D=16'h0300, ready=0 for 5 cycles -> code=9 and count=2 held. Raise ready -> code=8, then done.
- Empty word: load D=16'h0000 -> valid never rises; done=1 for exactly one cycle; busy=0 throughout.
- Load while busy: in SCAN with D=16'h0002, pulse load with D=16'hFFFF -> ignored. Only code=1 is emitted, then done; count never exceeds 1.

Source files
------------

// File: rtl/encoder_16x4_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential 16-to-4 encoder.
//   N  : number of request lines
//   W  : code width, log2(N)
//   CW : pending-count width, wide enough to hold N
package encoder_16x4_seq_pkg;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 5;

  typedef enum logic {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

  // Number of set bits in a request word.
  function automatic logic [CW-1:0] popcount16(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/encoder_16x4_seq_prienc.sv
// Combinational 16-to-4 priority encoder; the highest set index wins.
// Ports:
//   req_i : request word
//   idx_o : index of the highest set bit (0 when req_i is empty)
//   any_o : at least one bit of req_i is set
module priority_encoder_16x4
  import encoder_16x4_seq_pkg::*;
(
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 priority encoder. Captures a request word in idle, then emits the
// index of each set bit, highest first, one per valid/ready handshake. A one-cycle done
// pulse follows the last handshake (or an empty load).
// Ports:
//   clk_i    : rising-edge clock
//   reset_i  : synchronous active-high reset
//   load_i   : capture d_i when idle
//   d_i      : request lines, d_i[15] has highest priority
//   ready_i  : consumer accepts the current code
//   code_o   : index of highest pending bit (0 when not valid)
//   valid_o  : code_o is meaningful
//   busy_o   : pending word non-empty
//   count_o  : number of pending bits, 0..16
//   done_o   : one-cycle pulse at end of word
module encoder_16x4_seq
  import encoder_16x4_seq_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [N-1:0]  d_i,
  input  logic          ready_i,
  output logic [W-1:0]  code_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic [CW-1:0] count_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  logic [W-1:0]  top_idx;
  logic          top_any;
  logic          scanning;

  priority_encoder_16x4 u_prienc (
    .req_i (pending_q),
    .idx_o (top_idx),
    .any_o (top_any)
  );

  assign scanning = (state_q == StScan);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          if (d_i != '0) begin
            pending_d = d_i;
            count_d   = popcount16(d_i);
            state_d   = StScan;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StScan: begin
        // load_i is deliberately ignored here, even on the final handshake.
        if (ready_i) begin
          pending_d = pending_q & ~(N'(1) << top_idx);
          count_d   = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // All outputs come straight from registered state; nothing depends on d_i.
  assign valid_o = scanning;
  assign busy_o  = scanning;
  assign code_o  = (scanning && top_any) ? top_idx : '0;
  assign count_o = count_q;
  assign done_o  = done_q;

endmodule
